// File: rtl/lap_countdown_timer.sv
// Stopwatch / countdown timer core with a prescaled time base, lap FIFO and alarm output.
// Sits between the debounced button strobes and the display/format logic.
module lap_countdown_timer #(
   parameter int unsigned CLK_DIV    = 1000000,
   parameter int unsigned COUNT_W    = 32,
   parameter int unsigned LAP_DEPTH  = 8,
   parameter int unsigned RING_TICKS = 300
) (
   input  logic                       clockSignal,
   input  logic                       resetN,
   input  logic                       startOrStop,
   input  logic                       splitOrReset,
   input  logic                       countDownMode,
   input  logic                       loadStrobe,
   input  logic [COUNT_W-1:0]         loadCount,
   input  logic                       lapPop,
   output logic [COUNT_W-1:0]         countValue,
   output logic                       running,
   output logic                       lapValid,
   output logic [COUNT_W-1:0]         lapData,
   output logic [$clog2(LAP_DEPTH):0] lapLevel,
   output logic                       lapOverflow,
   output logic                       countOverflow,
   output logic                       ringSound
);

   localparam int unsigned PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PTR_W  = $clog2(LAP_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
   localparam int unsigned RING_W = (RING_TICKS > 0) ? $clog2(RING_TICKS + 1) : 1;

   localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_DIV - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
   localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
   localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(LAP_DEPTH);
   localparam logic [RING_W-1:0]  RING_LAST = RING_W'((RING_TICKS > 0) ? RING_TICKS - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_EXPIRED
   } state_t;

   state_t             state;
   logic               mode_q;
   logic [PRE_W-1:0]   presc;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] reload_q;
   logic               running_q;
   logic               ring_q;
   logic [RING_W-1:0]  ring_cnt;
   logic               count_ovf_q;
   logic               lap_ovf_q;

   logic [COUNT_W-1:0] lap_mem [LAP_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   level;

   logic               active;
   logic               tick;
   logic               run_mode;
   logic               expire;
   logic               do_clear;
   logic               push_req;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop_ok;
   logic               push_ok;
   logic               push_drop;
   logic [COUNT_W-1:0] clear_value;

   // The prescaler free-runs in EXPIRED too, so the ring duration is measured in ticks.
   assign active   = (state == S_RUN) || (state == S_EXPIRED);
   assign tick     = active && (presc == PRE_LAST);

   // In IDLE the live mode input governs; elsewhere the mode latched on leaving IDLE.
   assign run_mode    = (state == S_IDLE) ? countDownMode : mode_q;
   assign clear_value = run_mode ? reload_q : '0;

   assign expire   = (state == S_RUN) && tick && mode_q && (count_q <= COUNT_ONE);
   assign do_clear = splitOrReset && !startOrStop && ((state == S_IDLE) || (state == S_PAUSED));
   assign push_req = splitOrReset && !startOrStop && (state == S_RUN) && !mode_q;

   assign fifo_full  = (level == LVL_FULL);
   assign fifo_empty = (level == '0);
   assign pop_ok     = lapPop && !fifo_empty && !do_clear;
   assign push_ok    = push_req && (!fifo_full || pop_ok);
   assign push_drop  = push_req && fifo_full && !pop_ok;

   always_ff @(posedge clockSignal or negedge resetN) begin
      if (!resetN) begin
         state       <= S_IDLE;
         mode_q      <= 1'b0;
         presc       <= '0;
         count_q     <= '0;
         reload_q    <= '0;
         running_q   <= 1'b0;
         ring_q      <= 1'b0;
         ring_cnt    <= '0;
         count_ovf_q <= 1'b0;
      end else begin
         if (active) begin
            presc <= tick ? '0 : presc + 1'b1;
         end

         case (state)
            S_IDLE: begin
               mode_q <= countDownMode;
               if (startOrStop) begin
                  if (!(countDownMode && (count_q == '0))) begin
                     state     <= S_RUN;
                     running_q <= 1'b1;
                     presc     <= '0;
                  end
               end else if (splitOrReset) begin
                  count_q     <= clear_value;
                  count_ovf_q <= 1'b0;
               end else if (loadStrobe) begin
                  count_q  <= loadCount;
                  reload_q <= loadCount;
               end
            end

            S_RUN: begin
               if (tick) begin
                  if (mode_q) begin
                     count_q <= expire ? '0 : count_q - 1'b1;
                  end else if (count_q == COUNT_MAX) begin
                     count_ovf_q <= 1'b1;
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end
               // Expiry beats a coincident stop: the stop strobe is discarded.
               if (expire) begin
                  state     <= S_EXPIRED;
                  running_q <= 1'b0;
                  ring_q    <= 1'b1;
                  ring_cnt  <= '0;
               end else if (startOrStop) begin
                  state     <= S_PAUSED;
                  running_q <= 1'b0;
               end
            end

            S_PAUSED: begin
               if (startOrStop) begin
                  state     <= S_RUN;
                  running_q <= 1'b1;
               end else if (splitOrReset) begin
                  count_q     <= clear_value;
                  count_ovf_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end

            S_EXPIRED: begin
               if (startOrStop || splitOrReset) begin
                  state  <= S_IDLE;
                  ring_q <= 1'b0;
               end else if (tick && ring_q && (RING_TICKS != 0)) begin
                  if (ring_cnt == RING_LAST) begin
                     ring_q <= 1'b0;
                  end else begin
                     ring_cnt <= ring_cnt + 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clockSignal or negedge resetN) begin
      if (!resetN) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         lap_ovf_q <= 1'b0;
      end else if (do_clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         lap_ovf_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push_drop) begin
            lap_ovf_q <= 1'b1;
         end
      end
   end

   // NOTE: lap storage has no reset; lapData is masked with lapValid so stale entries never show.
   always_ff @(posedge clockSignal) begin
      if (push_ok) begin
         lap_mem[wr_ptr] <= count_q;
      end
   end

   assign countValue    = count_q;
   assign running       = running_q;
   assign lapValid      = !fifo_empty;
   assign lapData       = fifo_empty ? '0 : lap_mem[rd_ptr];
   assign lapLevel      = level;
   assign lapOverflow   = lap_ovf_q;
   assign countOverflow = count_ovf_q;
   assign ringSound     = ring_q;

endmodule

// File: tb/tb_lap_countdown_timer.sv
// Bench for lap_countdown_timer: directed scenarios with fixed expectations, then
// randomized strobes checked every cycle against a queue-based behavioural model.
module tb_lap_countdown_timer;

   localparam int DIV   = 4;
   localparam int CW    = 16;
   localparam int DEPTH = 4;
   localparam int RT    = 3;
   localparam int MAXV  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetN;
   logic          startOrStop, splitOrReset, countDownMode, loadStrobe, lapPop;
   logic [CW-1:0] loadCount;
   logic [CW-1:0] countValue, lapData;
   logic          running, lapValid, lapOverflow, countOverflow, ringSound;
   logic [2:0]    lapLevel;

   logic          s_rst_n, s_start, s_split, s_mode, s_load, s_pop;
   logic [3:0]    s_load_count, s_count, s_lap_data;
   logic          s_running, s_lap_valid, s_lap_ovf, s_cnt_ovf, s_ring;
   logic [2:0]    s_lap_level;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   lap_countdown_timer #(.CLK_DIV(DIV), .COUNT_W(CW), .LAP_DEPTH(DEPTH), .RING_TICKS(RT)) dut (
      .clockSignal(clk), .resetN(resetN), .startOrStop(startOrStop), .splitOrReset(splitOrReset),
      .countDownMode(countDownMode), .loadStrobe(loadStrobe), .loadCount(loadCount), .lapPop(lapPop),
      .countValue(countValue), .running(running), .lapValid(lapValid), .lapData(lapData),
      .lapLevel(lapLevel), .lapOverflow(lapOverflow), .countOverflow(countOverflow),
      .ringSound(ringSound)
   );

   lap_countdown_timer #(.CLK_DIV(DIV), .COUNT_W(4), .LAP_DEPTH(DEPTH), .RING_TICKS(RT)) dut_sat (
      .clockSignal(clk), .resetN(s_rst_n), .startOrStop(s_start), .splitOrReset(s_split),
      .countDownMode(s_mode), .loadStrobe(s_load), .loadCount(s_load_count), .lapPop(s_pop),
      .countValue(s_count), .running(s_running), .lapValid(s_lap_valid), .lapData(s_lap_data),
      .lapLevel(s_lap_level), .lapOverflow(s_lap_ovf), .countOverflow(s_cnt_ovf),
      .ringSound(s_ring)
   );

   // ---------------- behavioural reference model ----------------
   typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mstate_t;
   mstate_t ms;
   bit      m_cd, m_ring, m_lap_ovf, m_cnt_ovf;
   int      m_active, m_count, m_reload, m_rings;
   int      m_laps[$];

   task automatic model_reset();
      ms = M_IDLE; m_cd = 0; m_ring = 0; m_lap_ovf = 0; m_cnt_ovf = 0;
      m_active = 0; m_count = 0; m_reload = 0; m_rings = 0;
      m_laps.delete();
   endtask

   task automatic model_step();
      bit timed = (ms == M_RUN) || (ms == M_EXPIRED);
      bit tk    = timed && ((m_active % DIV) == DIV - 1);
      bit cd    = (ms == M_IDLE) ? countDownMode : m_cd;
      bit clr   = splitOrReset && !startOrStop && (ms == M_IDLE || ms == M_PAUSED);
      bit push  = splitOrReset && !startOrStop && ms == M_RUN && !m_cd;
      int snap  = m_count;
      if (clr) begin
         m_laps.delete();
         m_lap_ovf = 0;
      end else begin
         if (lapPop && m_laps.size() > 0) void'(m_laps.pop_front());
         if (push) begin
            if (m_laps.size() < DEPTH) m_laps.push_back(snap);
            else m_lap_ovf = 1;
         end
      end
      if (timed) m_active++;
      case (ms)
         M_IDLE: begin
            m_cd = countDownMode;
            if (startOrStop) begin
               if (!(cd && m_count == 0)) begin ms = M_RUN; m_active = 0; end
            end else if (splitOrReset) begin
               m_count = cd ? m_reload : 0; m_cnt_ovf = 0;
            end else if (loadStrobe) begin
               m_count = int'(loadCount); m_reload = int'(loadCount);
            end
         end
         M_RUN: begin
            if (tk) begin
               if (m_cd) begin
                  m_count = m_count - 1;
                  if (m_count == 0) begin ms = M_EXPIRED; m_ring = 1; m_rings = 0; end
               end else if (m_count == MAXV) m_cnt_ovf = 1;
               else m_count = m_count + 1;
            end
            if (startOrStop && ms == M_RUN) ms = M_PAUSED;
         end
         M_PAUSED: begin
            if (startOrStop) ms = M_RUN;
            else if (splitOrReset) begin
               m_count = m_cd ? m_reload : 0; m_cnt_ovf = 0; ms = M_IDLE;
            end
         end
         M_EXPIRED: begin
            if (startOrStop || splitOrReset) begin ms = M_IDLE; m_ring = 0; end
            else if (tk && m_ring) begin
               m_rings++;
               if (m_rings == RT) m_ring = 0;
            end
         end
         default: ;
      endcase
   endtask

   function automatic logic [39:0] exp_vec();
      logic [CW-1:0] head = (m_laps.size() > 0) ? CW'(m_laps[0]) : '0;
      return {CW'(m_count), (ms == M_RUN), (m_laps.size() > 0), 3'(m_laps.size()),
              m_lap_ovf, m_cnt_ovf, m_ring, head};
   endfunction

   function automatic logic [39:0] got_vec();
      return {countValue, running, lapValid, lapLevel, lapOverflow, countOverflow, ringSound, lapData};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      if (resetN) model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      startOrStop = 0; splitOrReset = 0; loadStrobe = 0; lapPop = 0;
   endtask

   task automatic wait_count(input int target);
      int n = 0;
      while (countValue != CW'(target) && n < 200) begin cyc(); n++; end
      if (n >= 200) begin
         n_checks++;
         $display("FAIL wait_count: count stuck at %0d, wanted %0d", countValue, target);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetN = 0; s_rst_n = 0;
      model_reset();
      cyc(); cyc();
      n_checks++;
      if (got_vec() !== 40'h0) $display("FAIL reset_outputs: got %h want 0", got_vec());
      else n_pass++;
      resetN = 1; s_rst_n = 1;
      cyc();
      n_checks++;
      if (got_vec() !== 40'h0) $display("FAIL reset_idle: got %h want 0", got_vec());
      else n_pass++;
   endtask

   task automatic test_stopwatch();
      countDownMode = 0; cyc();
      startOrStop = 1; cyc(); startOrStop = 0;
      repeat (39) cyc();
      startOrStop = 1; cyc(); startOrStop = 0;
      n_checks++;
      if (countValue !== 16'd10 || running !== 1'b0)
         $display("FAIL sw_stop: count=%0d running=%0b want 10/0", countValue, running);
      else n_pass++;
      startOrStop = 1; cyc(); startOrStop = 0;
      repeat (8) cyc();
      n_checks++;
      if (countValue !== 16'd12 || running !== 1'b1)
         $display("FAIL sw_resume: count=%0d running=%0b want 12/1", countValue, running);
      else n_pass++;
      startOrStop = 1; cyc(); startOrStop = 0;
      splitOrReset = 1; cyc(); splitOrReset = 0;
      n_checks++;
      if (countValue !== 16'd0 || running !== 1'b0)
         $display("FAIL sw_clear: count=%0d running=%0b want 0/0", countValue, running);
      else n_pass++;
   endtask

   task automatic test_laps();
      int marks[5] = '{2, 5, 7, 9, 11};
      startOrStop = 1; cyc(); startOrStop = 0;
      foreach (marks[i]) begin
         wait_count(marks[i]);
         splitOrReset = 1; cyc(); splitOrReset = 0;
      end
      n_checks++;
      if (lapLevel !== 3'd4 || lapOverflow !== 1'b1)
         $display("FAIL lap_full: level=%0d ovf=%0b want 4/1", lapLevel, lapOverflow);
      else n_pass++;
      startOrStop = 1; cyc(); startOrStop = 0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (lapValid !== 1'b1 || lapData !== CW'(marks[i]))
            $display("FAIL lap_pop%0d: valid=%0b data=%0d want 1/%0d", i, lapValid, lapData, marks[i]);
         else n_pass++;
         lapPop = 1; cyc(); lapPop = 0;
      end
      n_checks++;
      if (lapValid !== 1'b0 || lapLevel !== 3'd0)
         $display("FAIL lap_empty: valid=%0b level=%0d want 0/0", lapValid, lapLevel);
      else n_pass++;
      splitOrReset = 1; cyc(); splitOrReset = 0;
      n_checks++;
      if (lapOverflow !== 1'b0 || countValue !== 16'd0)
         $display("FAIL lap_clear: ovf=%0b count=%0d want 0/0", lapOverflow, countValue);
      else n_pass++;
   endtask

   task automatic test_countdown();
      countDownMode = 1; cyc();
      loadCount = 16'd5; loadStrobe = 1; cyc(); loadStrobe = 0;
      n_checks++;
      if (countValue !== 16'd5) $display("FAIL cd_load: count=%0d want 5", countValue);
      else n_pass++;
      startOrStop = 1; cyc(); startOrStop = 0;
      repeat (19) cyc();
      n_checks++;
      if (countValue !== 16'd1 || running !== 1'b1 || ringSound !== 1'b0)
         $display("FAIL cd_pre: count=%0d run=%0b ring=%0b want 1/1/0", countValue, running, ringSound);
      else n_pass++;
      cyc();
      n_checks++;
      if (countValue !== 16'd0 || running !== 1'b0 || ringSound !== 1'b1)
         $display("FAIL cd_expire: count=%0d run=%0b ring=%0b want 0/0/1", countValue, running, ringSound);
      else n_pass++;
      repeat (11) cyc();
      n_checks++;
      if (ringSound !== 1'b1) $display("FAIL ring_hold: ring=%0b want 1", ringSound);
      else n_pass++;
      cyc();
      n_checks++;
      if (ringSound !== 1'b0) $display("FAIL ring_end: ring=%0b want 0", ringSound);
      else n_pass++;
      startOrStop = 1; cyc(); startOrStop = 0;
   endtask

   task automatic test_acknowledge();
      loadCount = 16'd2; loadStrobe = 1; cyc(); loadStrobe = 0;
      startOrStop = 1; cyc(); startOrStop = 0;
      repeat (8) cyc();
      n_checks++;
      if (ringSound !== 1'b1) $display("FAIL ack_ring: ring=%0b want 1", ringSound);
      else n_pass++;
      startOrStop = 1; cyc(); startOrStop = 0;
      n_checks++;
      if (ringSound !== 1'b0 || countValue !== 16'd0 || running !== 1'b0)
         $display("FAIL ack_idle: ring=%0b count=%0d run=%0b want 0/0/0", ringSound, countValue, running);
      else n_pass++;
      loadCount = 16'd0; loadStrobe = 1; cyc(); loadStrobe = 0;
      startOrStop = 1; cyc(); startOrStop = 0;
      cyc();
      n_checks++;
      if (running !== 1'b0 || countValue !== 16'd0)
         $display("FAIL cd_zero_start: run=%0b count=%0d want 0/0", running, countValue);
      else n_pass++;
   endtask

   task automatic test_conflicts();
      countDownMode = 0; cyc();
      startOrStop = 1; cyc(); startOrStop = 0;
      repeat (9) cyc();
      startOrStop = 1; cyc(); startOrStop = 0;
      startOrStop = 1; splitOrReset = 1; cyc(); startOrStop = 0; splitOrReset = 0;
      n_checks++;
      if (running !== 1'b1 || countValue !== 16'd2 || lapLevel !== 3'd0)
         $display("FAIL start_split: run=%0b count=%0d level=%0d want 1/2/0", running, countValue, lapLevel);
      else n_pass++;
      startOrStop = 1; cyc(); startOrStop = 0;
      splitOrReset = 1; cyc(); splitOrReset = 0;
   endtask

   task automatic test_saturation();
      s_mode = 0; cyc();
      s_start = 1; cyc(); s_start = 0;
      repeat (64) cyc();
      n_checks++;
      if (s_count !== 4'd15 || s_cnt_ovf !== 1'b1 || s_running !== 1'b1)
         $display("FAIL sat_hold: count=%0d ovf=%0b run=%0b want 15/1/1", s_count, s_cnt_ovf, s_running);
      else n_pass++;
      repeat (3) cyc();
      #1 s_rst_n = 0;
      #1;
      n_checks++;
      if ({s_count, s_running, s_lap_valid, s_lap_data, s_lap_level, s_lap_ovf, s_cnt_ovf, s_ring} !== 16'h0)
         $display("FAIL sat_reset: count=%0d ovf=%0b run=%0b want all 0", s_count, s_cnt_ovf, s_running);
      else n_pass++;
      #1 s_rst_n = 1;
      cyc();
   endtask

   task automatic test_random();
      int errs = 0;
      resetN = 0; model_reset(); idle_inputs(); cyc();
      resetN = 1; cyc();
      for (int i = 0; i < 3000; i++) begin
         startOrStop  = ($urandom_range(0, 19) == 0);
         splitOrReset = ($urandom_range(0, 9) == 0);
         loadStrobe   = ($urandom_range(0, 11) == 0);
         loadCount    = CW'($urandom_range(0, 12));
         lapPop       = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 29) == 0) countDownMode = ~countDownMode;
         if ($urandom_range(0, 599) == 0) begin
            #1 resetN = 0;
            #1 model_reset();
            n_checks++;
            if (got_vec() !== exp_vec()) begin
               $display("FAIL rand_async_reset: got %h want %h", got_vec(), exp_vec());
               errs++;
            end else n_pass++;
            #1 resetN = 1;
         end
         cyc();
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            if (errs < 10)
               $display("FAIL rand_cycle%0d: got %h want %h", i, got_vec(), exp_vec());
            errs++;
         end else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      countDownMode = 0; loadCount = '0;
      s_start = 0; s_split = 0; s_mode = 0; s_load = 0; s_pop = 0; s_load_count = '0;
      resetN = 0; s_rst_n = 0;
      model_reset();
      test_reset();
      test_stopwatch();
      test_laps();
      test_countdown();
      test_acknowledge();
      test_conflicts();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
